// File: rtl/snoop_rr_arbiter_if.sv
// Bus bundle between the four L1 snoop ports and the snoop arbiter.
// The master side drives requests; the slave side is the arbiter.
interface snoop_rr_arbiter_if;
  logic [2:0]  sp_in_0;
  logic [2:0]  sp_in_1;
  logic [2:0]  sp_in_2;
  logic [2:0]  sp_in_3;
  logic [23:0] addr_sp_0;
  logic [23:0] addr_sp_1;
  logic [23:0] addr_sp_2;
  logic [23:0] addr_sp_3;
  logic        owned_0;
  logic        owned_1;
  logic        owned_2;
  logic        owned_3;
  logic [2:0]  sp_out;
  logic [23:0] addr_sp_out;
  logic [1:0]  share_num;
  logic [3:0]  sp_ack;
  logic        busy;
  logic        timeout;

  modport master (
    output sp_in_0, sp_in_1, sp_in_2, sp_in_3,
    output addr_sp_0, addr_sp_1, addr_sp_2, addr_sp_3,
    output owned_0, owned_1, owned_2, owned_3,
    input  sp_out, addr_sp_out, share_num, sp_ack, busy, timeout
  );

  modport slave (
    input  sp_in_0, sp_in_1, sp_in_2, sp_in_3,
    input  addr_sp_0, addr_sp_1, addr_sp_2, addr_sp_3,
    input  owned_0, owned_1, owned_2, owned_3,
    output sp_out, addr_sp_out, share_num, sp_ack, busy, timeout
  );
endinterface

// File: rtl/snoop_rr_arbiter.sv
// Round-robin snoop arbiter: grants one of four L1 requesters, broadcasts, collects owners.
// Optional WAIT timeout is enabled by defining SNOOP_TIMEOUT_EN.
module snoop_rr_arbiter #(
  parameter int TO_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  snoop_rr_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BCAST   = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  grant_reg;
  logic [1:0]  ptr_reg;
  logic [2:0]  code_reg;
  logic [23:0] addr_reg;
  logic [1:0]  share_reg, share_next;

  logic [2:0]  sp_in_arr [4];
  logic [23:0] addr_arr  [4];
  logic [3:0]  owned_vec;
  logic [3:0]  req_vec;
  logic [3:0]  owned_mask;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        grant_active;
  logic        to_hit;

  assign sp_in_arr[0] = bus.sp_in_0;
  assign sp_in_arr[1] = bus.sp_in_1;
  assign sp_in_arr[2] = bus.sp_in_2;
  assign sp_in_arr[3] = bus.sp_in_3;
  assign addr_arr[0]  = bus.addr_sp_0;
  assign addr_arr[1]  = bus.addr_sp_1;
  assign addr_arr[2]  = bus.addr_sp_2;
  assign addr_arr[3]  = bus.addr_sp_3;
  assign owned_vec    = {bus.owned_3, bus.owned_2, bus.owned_1, bus.owned_0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_req
      assign req_vec[gi] = |sp_in_arr[gi];
    end
  endgenerate

  // Scan from the highest offset down so the requester nearest ptr_reg wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_vec[ptr_reg + 2'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr_reg + 2'(k);
      end
    end
  end

  assign grant_active = req_vec[grant_reg];

  // The granted cache's own owned flag never counts toward sharers.
  assign owned_mask = owned_vec & ~(4'b0001 << grant_reg);
  assign share_next = {1'b0, owned_mask[0]} + {1'b0, owned_mask[1]}
                    + {1'b0, owned_mask[2]} + {1'b0, owned_mask[3]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (pick_valid) state_next = ST_BCAST;
      ST_BCAST:   state_next = ST_COLLECT;
      ST_COLLECT: state_next = ST_WAIT;
      ST_WAIT:    if (!grant_active || to_hit) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= 2'd0;
      ptr_reg   <= 2'd0;
      code_reg  <= 3'd0;
      addr_reg  <= 24'd0;
      share_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && pick_valid) begin
        grant_reg <= pick_idx;
        code_reg  <= sp_in_arr[pick_idx];
        addr_reg  <= addr_arr[pick_idx];
      end
      if (state_reg == ST_COLLECT) begin
        share_reg <= share_next;
      end
      if (state_reg == ST_WAIT && state_next == ST_IDLE) begin
        ptr_reg <= grant_reg + 2'd1;
      end
    end
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_reg;

  assign to_hit = (state_reg == ST_WAIT) && grant_active &&
                  (to_cnt_reg == TO_W'(TO_CYCLES - 1));

  // Counter restarts outside WAIT so every grant gets the full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= to_hit;
      if (state_reg == ST_WAIT && state_next == ST_WAIT) begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

  assign bus.timeout = timeout_reg;
`else
  logic unused_to_cfg;

  assign to_hit        = 1'b0;
  assign bus.timeout   = 1'b0;
  assign unused_to_cfg = (TO_CYCLES > 0);
`endif

  assign bus.sp_out      = (state_reg == ST_BCAST || state_reg == ST_COLLECT) ? code_reg : 3'b000;
  assign bus.addr_sp_out = addr_reg;
  assign bus.share_num   = share_reg;
  assign bus.sp_ack      = (state_reg == ST_WAIT) ? (4'b0001 << grant_reg) : 4'b0000;
  assign bus.busy        = (state_reg != ST_IDLE);

endmodule
